conv_linebuf_ctrl: RTL and testbench

- Sequences the 3-row convolution line buffer (`conv_shiftreg`) from a raw pixel stream.
- Counts columns and rows, and generates the line buffer's write enable, read enable and line handshake.
- Flushes one zero-padded line at end of frame so the last image row still reaches the window output.
- Reports window coordinates and frame status to the downstream 3x3 convolution engine.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_linebuf_ctrl_if.sv | 37 +++
 rtl/conv_pos_cnt.sv | 41 ++++
 rtl/conv_linebuf_ctrl.sv | 139 +++++++++++++
 tb/tb_conv_linebuf_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution line-buffer path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package conv_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_FILL   = ST_FILL,
    S_STREAM = ST_STREAM,
    S_FLUSH  = ST_FLUSH
  } state_t;

  // Default frame geometry, shared with conv_shiftreg and its bench.
  localparam int H_DEF  = 418;
  localparam int V_DEF  = 418;
  localparam int DW_DEF = 16;
  localparam int CW_DEF = 16;

endpackage

// File: rtl/conv_linebuf_ctrl_if.sv
// Pixel-in / line-buffer-out / window-status bundle for conv_linebuf_ctrl.
// Latency: none (wiring only).
// Backpressure: in_ready qualifies in_valid; all other outputs are unconditioned.
interface conv_linebuf_ctrl_if
  import conv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
);
  logic          in_sof;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          sr_wr_en;
  logic [DW-1:0] sr_wr_data;
  logic          sr_rd_en;
  logic          sr_rd_hs;
  logic          win_valid;
  logic [CW-1:0] win_col;
  logic [CW-1:0] win_row;
  logic          frame_done;
  logic          sof_err;

  // Pixel source and window consumer side.
  modport master (
    output in_sof, in_valid, in_data,
    input  in_ready, sr_wr_en, sr_wr_data, sr_rd_en, sr_rd_hs,
    input  win_valid, win_col, win_row, frame_done, sof_err
  );

  // Controller side.
  modport slave (
    input  in_sof, in_valid, in_data,
    output in_ready, sr_wr_en, sr_wr_data, sr_rd_en, sr_rd_hs,
    output win_valid, win_col, win_row, frame_done, sof_err
  );
endinterface

// File: rtl/conv_pos_cnt.sv
// Column/row position counter with line and frame wrap flags.
// Latency: counts update on the edge after inc/clr; flags are combinational.
// Backpressure: holds while inc is low; clr has priority over inc.
module conv_pos_cnt #(
  parameter int H  = 418,
  parameter int V  = 418,
  parameter int CW = 16
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          eol,
  output logic          eof
);

  assign eol = (col == CW'(H - 1));
  assign eof = eol && (row == CW'(V - 1));

  // clr with inc means the (0,0) pixel is consumed in the same cycle, so the
  // next position is column 1.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= inc ? CW'(1) : '0;
      row <= '0;
    end else if (inc) begin
      if (eol) begin
        col <= '0;
        row <= eof ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_linebuf_ctrl.sv
// Sequences the 3-row line buffer from a pixel stream and tags window positions.
// Latency: write 1 cycle after acceptance; window status 1 cycle after the read.
// Backpressure: in_ready drops for one cycle per line end and for the whole flush line.
module conv_linebuf_ctrl
  import conv_pkg::*;
#(
  parameter int H  = H_DEF,
  parameter int V  = V_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input logic               pclk,
  input logic               rst,
  conv_linebuf_ctrl_if.slave bus
);

  state_t        state;
  logic          in_ready_q, gap_q, hs_q, flush_done_q, frame_done_q, sof_err_q;
  logic          wr_en_q, rd_en_q, win_valid_q;
  logic [DW-1:0] wr_data_q;
  logic [CW-1:0] wcol_q, wrow_q, win_col_q, win_row_q;
  logic [CW-1:0] col, row, iss_col, iss_row;
  logic          eol, eof;
  logic          take, sof_take, issue, is_flush, iss_eol, iss_eof, cnt_clr, cnt_inc;

  assign take     = bus.in_valid & in_ready_q;
  assign sof_take = take & bus.in_sof;

  // Decide whether a line-buffer write is issued this cycle and where it comes from.
  always_comb begin
    issue    = 1'b0;
    is_flush = 1'b0;
    case (state)
      S_IDLE:           issue = sof_take;
      S_FILL, S_STREAM: issue = take;
      S_FLUSH: begin
        is_flush = !gap_q && !flush_done_q;
        issue    = is_flush;
      end
      default: ;
    endcase
  end

  // An SOF pixel is always position (0,0), whatever the counters hold.
  assign iss_col = sof_take ? '0 : col;
  assign iss_row = sof_take ? '0 : row;
  assign iss_eol = issue && !sof_take && eol;
  assign iss_eof = iss_eol && eof;
  // The flush line ends on a clear alone so the counters rest at (0,0) in IDLE.
  assign cnt_clr = sof_take || (is_flush && eol);
  assign cnt_inc = issue && !(is_flush && eol);

  conv_pos_cnt #(.H(H), .V(V), .CW(CW)) u_pos (
    .pclk (pclk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .col  (col),
    .row  (row),
    .eol  (eol),
    .eof  (eof)
  );

  // Frame sequencing: IDLE -> FILL (rows 0,1) -> STREAM -> FLUSH (one zero line).
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      in_ready_q   <= 1'b1;
      flush_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      in_ready_q   <= !iss_eol;
      if (sof_take && state != S_IDLE) sof_err_q <= 1'b1;
      case (state)
        S_IDLE:   if (sof_take) state <= S_FILL;
        S_FILL:   if (iss_eol && row == CW'(1)) state <= S_STREAM;
        S_STREAM: begin
          if (sof_take) state <= S_FILL;
          else if (iss_eof) state <= S_FLUSH;
        end
        S_FLUSH: begin
          in_ready_q <= 1'b0;
          if (is_flush && eol) flush_done_q <= 1'b1;
          // hs of the flush line itself closes the frame.
          if (hs_q && flush_done_q) begin
            state        <= S_IDLE;
            in_ready_q   <= 1'b1;
            flush_done_q <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write stage, line-end gap/handshake, and the window stage one cycle behind the read.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      gap_q       <= 1'b0;
      hs_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_data_q   <= '0;
      wcol_q      <= '0;
      wrow_q      <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      gap_q   <= iss_eol;
      hs_q    <= gap_q;
      wr_en_q <= issue;
      rd_en_q <= issue && (is_flush || (state == S_STREAM && !sof_take));
      if (issue) begin
        wr_data_q <= is_flush ? '0 : bus.in_data;
        wcol_q    <= iss_col;
        wrow_q    <= is_flush ? CW'(V - 1) : iss_row - CW'(1);
      end
      win_valid_q <= rd_en_q;
      win_col_q   <= wcol_q;
      win_row_q   <= wrow_q;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.sr_wr_en   = wr_en_q;
  assign bus.sr_wr_data = wr_data_q;
  assign bus.sr_rd_en   = rd_en_q;
  assign bus.sr_rd_hs   = hs_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_row    = win_row_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sof_err    = sof_err_q;

endmodule

// File: tb/tb_conv_linebuf_ctrl.sv
// Bench for conv_linebuf_ctrl: small 8x4 frames against a frame-level model,
// plus a default-geometry instance for line period and fill latency.
// Drives inputs on the falling edge and samples outputs there too.
module tb_conv_linebuf_ctrl;
  localparam int AH = 8;
  localparam int AV = 4;

  logic pclk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  conv_linebuf_ctrl_if #(.DW(16), .CW(16)) ia ();
  conv_linebuf_ctrl_if #(.DW(16), .CW(16)) ib ();

  conv_linebuf_ctrl #(.H(AH), .V(AV), .DW(16), .CW(16)) dut_a (
    .pclk (pclk), .rst (rst), .bus (ia)
  );
  conv_linebuf_ctrl #(.H(418), .V(418), .DW(16), .CW(16)) dut_b (
    .pclk (pclk), .rst (rst), .bus (ib)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Observed activity of instance A
  logic [15:0] wq_data[$];
  bit          wq_rd[$];
  int          wq_cyc[$];
  int          rd_cyc[$];
  int          hs_cyc[$];
  int          fd_cyc[$];
  int          win_cyc[$];
  int          win_c[$];
  int          win_r[$];
  // Accepted stimulus for instance A
  logic [15:0] acc_data[$];
  bit          acc_sof[$];
  int          sof_cyc;
  // Expected activity of instance A
  logic [15:0] exp_data[$];
  bit          exp_rd[$];
  int          exp_wc[$];
  int          exp_wr[$];
  int          exp_hs;
  int          exp_fd;
  // Instance B observation
  int          hsb[$];
  int          b_first_wr, b_first_rd, b_rd_idx, b_nwr;

  always @(negedge pclk) begin
    if (ia.sr_wr_en) begin
      wq_data.push_back(ia.sr_wr_data);
      wq_rd.push_back(ia.sr_rd_en);
      wq_cyc.push_back(cyc);
      if (ia.sr_rd_en) rd_cyc.push_back(cyc);
    end
    if (ia.sr_rd_hs)   hs_cyc.push_back(cyc);
    if (ia.frame_done) fd_cyc.push_back(cyc);
    if (ia.win_valid) begin
      win_cyc.push_back(cyc);
      win_c.push_back(int'(ia.win_col));
      win_r.push_back(int'(ia.win_row));
    end
    if (ib.sr_wr_en) begin
      if (b_first_wr < 0) b_first_wr = cyc;
      if (ib.sr_rd_en && b_first_rd < 0) begin
        b_first_rd = cyc;
        b_rd_idx   = b_nwr;
      end
      b_nwr++;
    end
    if (ib.sr_rd_hs) hsb.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    wq_data.delete(); wq_rd.delete(); wq_cyc.delete(); rd_cyc.delete();
    hs_cyc.delete(); fd_cyc.delete(); win_cyc.delete(); win_c.delete(); win_r.delete();
    acc_data.delete(); acc_sof.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Offer n pixels on A with the given valid duty (percent); first carries sof if asked.
  task automatic send_a(input int n, input bit with_sof, input int duty);
    int          sent  = 0;
    int          guard = 0;
    bit          first = with_sof;
    logic [15:0] d     = 16'($urandom);
    while (sent < n && guard < 5000) begin
      @(negedge pclk);
      guard++;
      if ($urandom_range(99) < duty) begin
        ia.in_valid = 1'b1;
        ia.in_data  = d;
        ia.in_sof   = first;
        if (ia.in_ready) begin
          acc_data.push_back(d);
          acc_sof.push_back(first);
          if (first) sof_cyc = cyc;
          sent++;
          first = 1'b0;
          d     = 16'($urandom);
        end
      end else begin
        ia.in_valid = 1'b0;
        ia.in_sof   = 1'b0;
      end
    end
    if (sent < n) chk("send_timeout", 64'(sent), 64'(n));
    @(negedge pclk);
    ia.in_valid = 1'b0;
    ia.in_sof   = 1'b0;
  endtask

  // Frame-level reference: pixels before the first sof are dropped; every sof
  // starts a fresh frame at index 0; a complete frame is followed by one zero line.
  task automatic build_model();
    int idx     = 0;
    bit inframe = 1'b0;
    exp_data.delete(); exp_rd.delete(); exp_wc.delete(); exp_wr.delete();
    exp_hs = 0;
    exp_fd = 0;
    for (int k = 0; k < acc_data.size(); k++) begin
      if (acc_sof[k]) begin
        inframe = 1'b1;
        idx     = 0;
      end
      if (inframe) begin
        exp_data.push_back(acc_data[k]);
        exp_rd.push_back(idx >= 2 * AH);
        if (idx >= 2 * AH) begin
          exp_wc.push_back(idx % AH);
          exp_wr.push_back(idx / AH - 1);
        end
        if (idx % AH == AH - 1) exp_hs++;
        idx++;
        if (idx == AV * AH) begin
          for (int c = 0; c < AH; c++) begin
            exp_data.push_back(16'h0);
            exp_rd.push_back(1'b1);
            exp_wc.push_back(c);
            exp_wr.push_back(AV - 1);
          end
          exp_hs++;
          exp_fd++;
          inframe = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    build_model();
    chk({tag, "_nwr"}, 64'(wq_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < wq_data.size() && i < exp_data.size(); i++) begin
      chk({tag, "_wdata"}, 64'(wq_data[i]), 64'(exp_data[i]));
      chk({tag, "_rden"}, 64'(wq_rd[i]), 64'(exp_rd[i]));
    end
    chk({tag, "_nwin"}, 64'(win_c.size()), 64'(exp_wc.size()));
    for (int i = 0; i < win_c.size() && i < exp_wc.size(); i++) begin
      chk({tag, "_wincol"}, 64'(win_c[i]), 64'(exp_wc[i]));
      chk({tag, "_winrow"}, 64'(win_r[i]), 64'(exp_wr[i]));
    end
    for (int i = 0; i < win_cyc.size() && i < rd_cyc.size(); i++)
      chk({tag, "_winlat"}, 64'(win_cyc[i]), 64'(rd_cyc[i] + 1));
    chk({tag, "_nhs"}, 64'(hs_cyc.size()), 64'(exp_hs));
    chk({tag, "_nfd"}, 64'(fd_cyc.size()), 64'(exp_fd));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},   64'(ia.in_ready),   64'd1);
    chk({tag, "_sr_wr_en"},   64'(ia.sr_wr_en),   64'd0);
    chk({tag, "_sr_wr_data"}, 64'(ia.sr_wr_data), 64'd0);
    chk({tag, "_sr_rd_en"},   64'(ia.sr_rd_en),   64'd0);
    chk({tag, "_sr_rd_hs"},   64'(ia.sr_rd_hs),   64'd0);
    chk({tag, "_win_valid"},  64'(ia.win_valid),  64'd0);
    chk({tag, "_win_col"},    64'(ia.win_col),    64'd0);
    chk({tag, "_win_row"},    64'(ia.win_row),    64'd0);
    chk({tag, "_frame_done"}, 64'(ia.frame_done), 64'd0);
    chk({tag, "_sof_err"},    64'(ia.sof_err),    64'd0);
  endtask

  initial begin
    int nb;
    total = 0;
    bad   = 0;
    sof_cyc = 0;
    b_first_wr = -1; b_first_rd = -1; b_rd_idx = -1; b_nwr = 0;
    ia.in_valid = 1'b0; ia.in_sof = 1'b0; ia.in_data = '0;
    ib.in_valid = 1'b0; ib.in_sof = 1'b0; ib.in_data = '0;
    rst = 1'b0;

    // Reset values
    idle(3);
    check_reset("rst");
    chk("rst_b_in_ready", 64'(ib.in_ready), 64'd1);
    rst = 1'b1;
    idle(2);

    // Clean frame, continuous valid
    clear_all();
    send_a(AH * AV, 1'b1, 100);
    idle(40);
    compare_model("clean");
    chk("clean_first_wr_lat", 64'(wq_cyc.size() > 0 ? wq_cyc[0] : -1), 64'(sof_cyc + 1));
    if (hs_cyc.size() == AV + 1 && wq_cyc.size() == (AV + 1) * AH) begin
      for (int i = 0; i <= AV; i++)
        chk("clean_hs_after_eol", 64'(hs_cyc[i]), 64'(wq_cyc[AH * i + AH - 1] + 1));
      for (int i = 0; i < AV; i++)
        chk("clean_gap_at_hs", 64'(wq_cyc[AH * (i + 1)]), 64'(hs_cyc[i] + 1));
      if (fd_cyc.size() == 1) chk("clean_fd_time", 64'(fd_cyc[0]), 64'(hs_cyc[AV] + 1));
    end
    chk("clean_sof_err", 64'(ia.sof_err), 64'd0);
    chk("clean_idle_ready", 64'(ia.in_ready), 64'd1);

    // Data before sof is ignored
    clear_all();
    send_a(10, 1'b0, 100);
    send_a(AH * AV, 1'b1, 100);
    idle(40);
    compare_model("presof");
    chk("presof_first_wr_lat", 64'(wq_cyc.size() > 0 ? wq_cyc[0] : -1), 64'(sof_cyc + 1));

    // Random valid gaps
    clear_all();
    send_a(AH * AV, 1'b1, 50);
    idle(40);
    compare_model("gaps");

    // Mid-frame sof at (row 2, col 3)
    clear_all();
    send_a(2 * AH + 3, 1'b1, 100);
    chk("mid_err_before", 64'(ia.sof_err), 64'd0);
    send_a(AH * AV, 1'b1, 100);
    chk("mid_err_set", 64'(ia.sof_err), 64'd1);
    idle(40);
    compare_model("midsof");
    chk("mid_err_sticky", 64'(ia.sof_err), 64'd1);

    // Asynchronous reset mid-STREAM
    clear_all();
    send_a(2 * AH + 4, 1'b1, 100);
    @(posedge pclk);
    #2 rst = 1'b0;
    #1 check_reset("arst");
    idle(3);
    rst = 1'b1;
    clear_all();
    send_a(10, 1'b0, 100);
    idle(10);
    chk("arst_no_wr", 64'(wq_data.size()), 64'd0);
    chk("arst_no_hs", 64'(hs_cyc.size()), 64'd0);

    // Default geometry: line period and fill latency
    nb = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge pclk);
      ib.in_valid = 1'b1;
      ib.in_sof   = (nb == 0);
      ib.in_data  = 16'(nb);
      if (ib.in_ready) nb++;
    end
    @(negedge pclk);
    ib.in_valid = 1'b0;
    ib.in_sof   = 1'b0;
    chk("b_hs_count", 64'(hsb.size() >= 3), 64'd1);
    if (hsb.size() >= 3) begin
      chk("b_hs_period0", 64'(hsb[1] - hsb[0]), 64'd419);
      chk("b_hs_period1", 64'(hsb[2] - hsb[1]), 64'd419);
    end
    chk("b_rd_delay", 64'(b_first_rd - b_first_wr), 64'd838);
    chk("b_rd_index", 64'(b_rd_idx), 64'd836);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
